// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings for the EX-resolved branch redirect controller:
// FSM state codes, branch selector codes and counter widths.
package branch_redirect_ctrl_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_REDIRECT = 2'd1;
    localparam logic [1:0] ST_DRAIN    = 2'd2;

    // Branch_sel codes from decode; 0 and 1 both mean "not a control transfer".
    localparam logic [2:0] BR_NONE0 = 3'd0;
    localparam logic [2:0] BR_NONE1 = 3'd1;
    localparam logic [2:0] BR_BEQ   = 3'd2;
    localparam logic [2:0] BR_BNE   = 3'd3;
    localparam logic [2:0] BR_BLT   = 3'd4;
    localparam logic [2:0] BR_BGE   = 3'd5;
    localparam logic [2:0] BR_JAL   = 3'd6;
    localparam logic [2:0] BR_JALR  = 3'd7;

    localparam int unsigned DRAIN_CNT_W = 4;
    localparam int unsigned PERF_CNT_W  = 32;

endpackage

// File: rtl/branch_perf_counters.sv
// Free-running wrap-around event counters for resolved branches and issued redirects.
module branch_perf_counters
    import branch_redirect_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_event,
    input  logic                  redirect_event,
    output logic [PERF_CNT_W-1:0] branch_cnt,
    output logic [PERF_CNT_W-1:0] redirect_cnt
);

    logic [PERF_CNT_W-1:0] branch_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (branch_event) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (redirect_event) begin
                redirect_cnt_q <= redirect_cnt_q + 1'b1;
            end
        end
    end

    assign branch_cnt   = branch_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: captures a taken EX branch, redirects fetch, squashes and drains.
// Optional BRANCH_PERF_CNT_EN adds ex_is_branch and the perf_branch_cnt/perf_redirect_cnt outputs.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_take,
    input  logic            ex_jalr,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic [XLEN-1:0] redir_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            ex_hold,
`ifdef BRANCH_PERF_CNT_EN
    input  logic            ex_is_branch,
    output logic [31:0]     perf_branch_cnt,
    output logic [31:0]     perf_redirect_cnt,
`endif
    output logic            target_misalign
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);

    logic [1:0]             state_q, state_d;
    logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [XLEN-1:0]        redir_pc_q, redir_pc_d;
    logic                   misalign_q, misalign_d;

    logic [XLEN-1:0] base, sum, target;

    assign base   = ex_jalr ? ex_rs1 : ex_pc;
    assign sum    = base + ex_imm;
    assign target = ex_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        redir_pc_d  = redir_pc_q;
        misalign_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid && ex_take) begin
                    redir_pc_d = target;
                    misalign_d = |target[1:0];
                    state_d    = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (redir_ready) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                // Leaving on 1 gives exactly DRAIN_CYCLES flush cycles.
                if (drain_cnt_q <= 1) begin
                    state_d     = ST_IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            redir_pc_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            redir_pc_q  <= redir_pc_d;
            misalign_q  <= misalign_d;
        end
    end

    assign redir_valid     = (state_q == ST_REDIRECT);
    assign flush_id_ex     = (state_q == ST_REDIRECT);
    assign ex_hold         = (state_q == ST_REDIRECT);
    assign flush_if_id     = (state_q == ST_REDIRECT) || (state_q == ST_DRAIN);
    assign redir_pc        = redir_pc_q;
    assign target_misalign = misalign_q;

`ifdef BRANCH_PERF_CNT_EN
    branch_perf_counters u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_event   (ex_valid && ex_is_branch && (state_q == ST_IDLE)),
        .redirect_event (redir_valid && redir_ready),
        .branch_cnt     (perf_branch_cnt),
        .redirect_cnt   (perf_redirect_cnt)
    );
`endif

endmodule
